// File: rtl/iomem_log_fifo_if.sv
// iomem_log_fifo_if: PicoSoC iomem_* bus bundle.
//   master : CPU side, drives valid/wstrb/addr/wdata, receives ready/rdata.
//   slave  : peripheral side, the mirror image.
interface iomem_log_fifo_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_log_fifo.sv
// iomem_log_fifo: event-log FIFO on the PicoSoC iomem bus.
// Captures 32-bit words from a non-stallable source; the CPU drains them
// through memory-mapped registers (DATA/STATUS/THRESH/DROPS at +0x0..+0xC).
// Ports:
//   clk, reset       : single clock, synchronous active-high reset
//   iomem (slave)    : CPU access, one wait state, ready pulses one cycle
//   log_valid/data   : push strobe and event word, no backpressure
//   irq              : level interrupt, count >= THRESH (THRESH != 0)
module iomem_log_fifo #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic              clk,
  input  logic              reset,
  iomem_log_fifo_if.slave   iomem,
  input  logic              log_valid,
  input  logic [31:0]       log_data,
  output logic              irq
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   thresh_q, thresh_d;
  logic [15:0]   drops_q, drops_d;
  logic          ovf_q, ovf_d;
  logic          ready_q;
  logic          irq_q, irq_d;
  logic [31:0]   reg_rdata_q, reg_rdata_d;
  logic          data_sel_q, data_sel_d;
  logic [31:0]   ram_q;

  logic          sel, is_wr, pop, flush, drop_clr, push, drop;
  logic [1:0]    rsel;

  always_comb begin
    sel      = iomem.iomem_valid && (iomem.iomem_addr[31:24] == BASE_ADDR[31:24]) && !ready_q;
    is_wr    = |iomem.iomem_wstrb;
    rsel     = iomem.iomem_addr[3:2];
    pop      = sel && !is_wr && (rsel == 2'd0) && (count_q != '0);
    flush    = sel && is_wr && (rsel == 2'd1) && iomem.iomem_wdata[0];
    drop_clr = sel && is_wr && (rsel == 2'd3);
    // A pop committing this edge frees a slot, so a full FIFO still accepts.
    push     = log_valid && !flush && ((count_q != FULL_CNT) || pop);
    drop     = log_valid && !flush && !push;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    thresh_d    = thresh_q;
    drops_d     = drops_q;
    ovf_d       = ovf_q;
    reg_rdata_d = reg_rdata_q;
    data_sel_d  = data_sel_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
    end

    if (drop) begin
      ovf_d = 1'b1;
      if (drops_q != '1) drops_d = drops_q + 16'd1;
    end
    // Clearing wins over a drop landing in the same cycle.
    if (drop_clr) begin
      drops_d = '0;
      ovf_d   = 1'b0;
    end

    if (sel && is_wr && (rsel == 2'd2)) thresh_d = iomem.iomem_wdata[15:0];

    // Register reads return next-state values so STATUS includes this cycle's push.
    if (sel) begin
      data_sel_d  = pop;
      reg_rdata_d = '0;
      if (!is_wr) begin
        unique case (rsel)
          2'd1:    reg_rdata_d = {(count_d == '0), (count_d == FULL_CNT), ovf_d, 13'b0, 16'(count_d)};
          2'd2:    reg_rdata_d = {16'b0, thresh_d};
          2'd3:    reg_rdata_d = {16'b0, drops_d};
          default: reg_rdata_d = '0;
        endcase
      end
    end

    irq_d = (thresh_q != '0) && (17'(count_q) >= 17'(thresh_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      thresh_q    <= '0;
      drops_q     <= '0;
      ovf_q       <= 1'b0;
      ready_q     <= 1'b0;
      irq_q       <= 1'b0;
      reg_rdata_q <= '0;
      data_sel_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      thresh_q    <= thresh_d;
      drops_q     <= drops_d;
      ovf_q       <= ovf_d;
      ready_q     <= sel;
      irq_q       <= irq_d;
      reg_rdata_q <= reg_rdata_d;
      data_sel_q  <= data_sel_d;
    end
  end

  // Storage kept free of reset so it maps onto block RAM; read is registered
  // and only on a pop edge. When full, write and read hit the same address and
  // the read returns the old head.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr_q] <= log_data;
    if (pop && !reset)  ram_q <= mem[rd_ptr_q];
  end

  assign iomem.iomem_ready = ready_q;
  assign iomem.iomem_rdata = data_sel_q ? ram_q : reg_rdata_q;
  assign irq               = irq_q;

  logic unused_bits;
  assign unused_bits = ^{iomem.iomem_addr[23:4], iomem.iomem_addr[1:0], iomem.iomem_wdata[31:16]};

endmodule
